bin2bcd_seq: RTL and testbench

Sequential 10-bit binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It sits directly upstream of the three-digit BCD adder and produces one operand's ones, tens and hundreds digits. Inputs up to 1023 are accepted. Values above 999 raise `ovf`, and the digit outputs then carry the value modulo 1000. A start/busy/done handshake lets a controller convert the two adder operands one after the other.

---
 rtl/bin2bcd_seq.sv | 104 ++++++++++
 tb/tb_bin2bcd_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential 10-bit binary to 3-digit BCD converter (shift-and-add-3, one bit per clock).
// A start/busy/done handshake sequences conversions; ovf flags values above 999.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] bcd1,
  output logic [3:0] bcd10,
  output logic [3:0] bcd100,
  output logic       ovf
);

  // Handshake: start is sampled only in IDLE or DONE; bin is captured on that
  // accepting edge. busy is high in SHIFT, done pulses for the single DONE cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        accept;
  logic        last;
  logic [9:0]  sr;
  logic [15:0] scr;
  logic [15:0] scr_adj;
  logic [15:0] scr_sh;
  logic [3:0]  cnt;

  always_comb begin
    scr_adj = scr;
    for (int i = 0; i < 4; i++) begin
      if (scr[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
    end
  end

  assign scr_sh = {scr_adj[14:0], sr[9]};
  assign last   = (cnt == 4'd9);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr     <= '0;
      scr    <= '0;
      cnt    <= '0;
      bcd1   <= '0;
      bcd10  <= '0;
      bcd100 <= '0;
      ovf    <= 1'b0;
    end else if (accept) begin
      sr  <= bin;
      scr <= '0;
      cnt <= '0;
    end else if (state_q == SHIFT) begin
      sr  <= {sr[8:0], 1'b0};
      scr <= scr_sh;
      cnt <= cnt + 4'd1;
      if (last) begin
        bcd100 <= scr_sh[11:8];
        bcd10  <= scr_sh[7:4];
        bcd1   <= scr_sh[3:0];
        // a bit leaving the thousands digit would also mean the value exceeded 999
        ovf    <= |{scr_adj[15], scr_sh[15:12]};
      end
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: reset, single, sweep, random, ignored start,
// back-to-back and mid-conversion reset scenarios against a decimal-arithmetic model.
module tb_bin2bcd_seq;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic       start;
  logic [9:0] bin;
  logic       busy;
  logic       done;
  logic [3:0] bcd1;
  logic [3:0] bcd10;
  logic [3:0] bcd100;
  logic       ovf;

  int n_tests;
  int n_fail;

  logic [12:0] exp_q[$];

  bin2bcd_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .bcd1   (bcd1),
    .bcd10  (bcd10),
    .bcd100 (bcd100),
    .ovf    (ovf)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  // reference model: {ovf, hundreds, tens, ones} from plain decimal arithmetic
  function automatic logic [12:0] model(input int v);
    int m;
    m = v % 1000;
    model = {(v > 999) ? 1'b1 : 1'b0, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one conversion; pulse_k > 0 raises start with bin=7 in that cycle only
  task automatic do_conv(input logic [9:0] v, input bit noise, input int pulse_k,
                         output int busy_n, output int done_k, output bit both,
                         output bit chg, output bit done_after);
    logic [12:0] prev;
    int k;
    busy_n = 0; done_k = 0; both = 0; chg = 0;
    prev  = {ovf, bcd100, bcd10, bcd1};
    start = 1'b1;
    bin   = v;
    tick();
    start = 1'b0;
    k = 1;
    while (!done && k < 40) begin
      if (busy) busy_n++;
      if (busy && done) both = 1;
      if ({ovf, bcd100, bcd10, bcd1} !== prev) chg = 1;
      if (noise) bin = 10'($urandom_range(0, 1023));
      start = (pulse_k != 0 && k == pulse_k);
      if (start) bin = 10'd7;
      tick();
      k++;
    end
    start = 1'b0;
    if (done) begin
      done_k = k;
      if (busy) both = 1;
    end
    tick();
    done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bin = '0;
    #2;
    n_tests++;
    if ({busy, done, ovf, bcd100, bcd10, bcd1} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_no_clock: got %h required 0", {busy, done, ovf, bcd100, bcd10, bcd1});
    end
    clk_en = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if ({busy, done, ovf, bcd100, bcd10, bcd1} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_released_idle: got %h required 0", {busy, done, ovf, bcd100, bcd10, bcd1});
    end
  endtask

  task automatic test_single();
    int bn, dk; bit b, c, da;
    do_conv(10'd255, 0, 0, bn, dk, b, c, da);
    n_tests++;
    if (bn !== 10) begin n_fail++; $display("FAIL single_busy_cycles: got %0d required 10", bn); end
    n_tests++;
    if (dk !== 11) begin n_fail++; $display("FAIL single_done_cycle: got %0d required 11", dk); end
    n_tests++;
    if ({ovf, bcd100, bcd10, bcd1} !== {1'b0, 4'd2, 4'd5, 4'd5}) begin
      n_fail++;
      $display("FAIL single_result: got %h required 0255", {ovf, bcd100, bcd10, bcd1});
    end
    n_tests++;
    if (da !== 1'b0 || b !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done_pulse: done_after=%b both=%b required 0 0", da, b);
    end
  endtask

  task automatic test_sweep();
    int bn, dk; bit b, c, da;
    logic [12:0] e;
    for (int v = 0; v < 1024; v++) begin
      exp_q.push_back(model(v));
      do_conv(10'(v), 0, 0, bn, dk, b, c, da);
      e = exp_q.pop_front();
      n_tests++;
      if (dk !== 11 || {ovf, bcd100, bcd10, bcd1} !== e || b || c) begin
        n_fail++;
        $display("FAIL sweep bin=%0d: got %h lat=%0d both=%b chg=%b required %h lat=11", v,
                 {ovf, bcd100, bcd10, bcd1}, dk, b, c, e);
      end
      if (v == 0 || v == 999 || v == 1000 || v == 1023) begin
        n_tests++;
        if ((v == 0    && {ovf, bcd100, bcd10, bcd1} !== 13'h0000) ||
            (v == 999  && {ovf, bcd100, bcd10, bcd1} !== 13'h0999) ||
            (v == 1000 && {ovf, bcd100, bcd10, bcd1} !== 13'h1000) ||
            (v == 1023 && {ovf, bcd100, bcd10, bcd1} !== 13'h1023)) begin
          n_fail++;
          $display("FAIL spot bin=%0d: got %h", v, {ovf, bcd100, bcd10, bcd1});
        end
      end
    end
  endtask

  task automatic test_random();
    int bn, dk; bit b, c, da;
    int v;
    logic [12:0] e;
    for (int i = 0; i < 200; i++) begin
      v = $urandom_range(0, 1023);
      exp_q.push_back(model(v));
      do_conv(10'(v), 1, 0, bn, dk, b, c, da);
      e = exp_q.pop_front();
      n_tests++;
      if (dk !== 11 || bn !== 10 || {ovf, bcd100, bcd10, bcd1} !== e || da) begin
        n_fail++;
        $display("FAIL random bin=%0d: got %h lat=%0d busy=%0d required %h lat=11 busy=10", v,
                 {ovf, bcd100, bcd10, bcd1}, dk, bn, e);
      end
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
    end
  endtask

  task automatic test_ignored_start();
    int bn, dk; bit b, c, da;
    int extra_done;
    do_conv(10'd512, 0, 4, bn, dk, b, c, da);
    n_tests++;
    if (dk !== 11 || {ovf, bcd100, bcd10, bcd1} !== 13'h0512) begin
      n_fail++;
      $display("FAIL ignored_start_result: got %h lat=%0d required 0512 lat=11",
               {ovf, bcd100, bcd10, bcd1}, dk);
    end
    extra_done = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy || da) extra_done++;
      tick();
    end
    n_tests++;
    if (extra_done !== 0) begin
      n_fail++;
      $display("FAIL ignored_start_quiet: got %0d active cycles required 0", extra_done);
    end
  endtask

  task automatic test_back_to_back();
    int k, d1, d2;
    bit held, both;
    logic [12:0] r1;
    d1 = 0; d2 = 0; held = 1; both = 0; r1 = '0;
    start = 1'b1;
    bin   = 10'd42;
    tick();
    bin = 10'd987;
    k = 1;
    while (d2 == 0 && k < 60) begin
      if (busy && done) both = 1;
      if (done && d1 == 0) begin
        d1 = k;
        r1 = {ovf, bcd100, bcd10, bcd1};
      end else if (done) begin
        d2 = k;
      end else if (d1 != 0 && {ovf, bcd100, bcd10, bcd1} !== 13'h0042) begin
        held = 0;
      end
      if (d1 != 0 && !done) start = 1'b0;
      if (d2 == 0) begin
        tick();
        k++;
      end
    end
    start = 1'b0;
    n_tests++;
    if (d1 !== 11 || r1 !== 13'h0042) begin
      n_fail++;
      $display("FAIL b2b_first: got %h at %0d required 0042 at 11", r1, d1);
    end
    n_tests++;
    if (d2 - d1 !== 11 || {ovf, bcd100, bcd10, bcd1} !== 13'h0987) begin
      n_fail++;
      $display("FAIL b2b_second: got %h spacing %0d required 0987 spacing 11",
               {ovf, bcd100, bcd10, bcd1}, d2 - d1);
    end
    n_tests++;
    if (!held || both) begin
      n_fail++;
      $display("FAIL b2b_hold: held=%b both=%b required 1 0", held, both);
    end
    tick();
    tick();
  endtask

  task automatic test_mid_reset();
    int bn, dk; bit b, c, da;
    int seen;
    do_conv(10'd777, 0, 0, bn, dk, b, c, da);
    n_tests++;
    if ({ovf, bcd100, bcd10, bcd1} !== 13'h0777) begin
      n_fail++;
      $display("FAIL midrst_first: got %h required 0777", {ovf, bcd100, bcd10, bcd1});
    end
    start = 1'b1;
    bin   = 10'd123;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, ovf, bcd100, bcd10, bcd1} !== 15'd0) begin
      n_fail++;
      $display("FAIL midrst_async: got %h required 0", {busy, done, ovf, bcd100, bcd10, bcd1});
    end
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) seen++;
      tick();
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL midrst_no_done: got %0d active cycles required 0", seen);
    end
    do_conv(10'd123, 0, 0, bn, dk, b, c, da);
    n_tests++;
    if (dk !== 11 || {ovf, bcd100, bcd10, bcd1} !== 13'h0123) begin
      n_fail++;
      $display("FAIL midrst_after: got %h lat=%0d required 0123 lat=11",
               {ovf, bcd100, bcd10, bcd1}, dk);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk_en  = 1'b0;
    test_reset();
    test_single();
    test_sweep();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
